// File: rtl/bus_arbiter3.sv
// Round-robin arbiter for a three-input shared bus mux with bounded tenure.
// Owner holds the bus until its request drops or MAX_BEATS beats have been accepted.
module bus_arbiter3 #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       bus_ready,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       bus_valid,
    output logic       busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    logic [0:0]       state;
    logic [1:0]       owner;
    logic [1:0]       last_owner;
    logic [CNT_W-1:0] beat_cnt;

    logic [1:0] cand1, cand2, pick;
    logic       pick_ok;
    logic       owner_req;
    logic       beat;
    logic       last_beat;
    logic       rel;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Scan last_owner+1, +2, +3: the previous owner always comes last.
    always_comb begin
        cand1   = next_idx(last_owner);
        cand2   = next_idx(cand1);
        pick    = cand1;
        pick_ok = 1'b1;
        if (req[cand1])           pick = cand1;
        else if (req[cand2])      pick = cand2;
        else if (req[last_owner]) pick = last_owner;
        else                      pick_ok = 1'b0;
    end

    // Handshake: a beat transfers on a rising edge where bus_valid and bus_ready are both 1.
    assign owner_req = req[owner];
    assign busy      = (state == BUSY);
    assign bus_valid = busy & owner_req;
    assign beat      = bus_valid & bus_ready;
    assign last_beat = (MAX_BEATS != 0) && (beat_cnt == LAST_CNT);
    assign rel       = !owner_req || (beat && last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            beat_cnt   <= '0;
            grant      <= 3'b000;
            sel        <= 2'b11;
        end else if (state == IDLE) begin
            if (pick_ok) begin
                state    <= BUSY;
                owner    <= pick;
                grant    <= 3'b001 << pick;
                sel      <= pick;
                beat_cnt <= '0;
            end
        end else begin
            if (rel) begin
                state      <= IDLE;
                last_owner <= owner;
                grant      <= 3'b000;
                sel        <= 2'b11;
                beat_cnt   <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3: expected beat owners are queued by the stimulus
// and popped by a negedge monitor whenever a beat is accepted.
module tb_bus_arbiter3;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       bus_ready;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       bus_valid;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    bus_arbiter3 #(.MAX_BEATS(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bus_ready (bus_ready),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (act=timeout exp=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [2:0] g, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({g, s});
    endtask

    // monitor: every accepted beat must match the queued owner
    always @(negedge clk) begin
        if (rst_n) begin
            check("invariant", {7'd0, ((sel == 2'b11) == (grant == 3'b000)) && (busy == |grant)
                                      && $onehot0(grant)}, 8'd1);
            if (bus_valid && bus_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {3'd0, grant, sel}, 8'hff);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("beat_owner", {3'd0, grant, sel}, {3'd0, e});
                end
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0;
        req = 3'b111;
        bus_ready = 1'b1;

        // 1 reset held with all requests
        tick(3);
        check("rst_grant", {5'd0, grant}, 8'h00);
        check("rst_sel", {6'd0, sel}, 8'h03);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_valid", {7'd0, bus_valid}, 8'h00);
        req = 3'b000;
        rst_n = 1'b1;
        tick(1);

        // 2 single requester, 3 beats then drop
        req = 3'b010;
        push_beats(3'b010, 2'b01, 3);
        tick(1);
        check("single_grant", {5'd0, grant}, 8'h02);
        check("single_sel", {6'd0, sel}, 8'h01);
        tick(3);
        req = 3'b000;
        tick(1);
        check("single_idle_sel", {6'd0, sel}, 8'h03);
        check("single_idle_busy", {7'd0, busy}, 8'h00);

        // 3 rotation from a fresh reset
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        req = 3'b111;
        push_beats(3'b001, 2'b00, 4);
        push_beats(3'b010, 2'b01, 4);
        push_beats(3'b100, 2'b10, 4);
        push_beats(3'b001, 2'b00, 4);
        tick(5);
        check("rot_bubble_grant", {5'd0, grant}, 8'h00);
        tick(1);
        check("rot_second_grant", {5'd0, grant}, 8'h02);
        tick(14);
        req = 3'b000;
        tick(1);
        check("rot_end_grant", {5'd0, grant}, 8'h00);

        // 4 stall mid-burst for owner 0
        req = 3'b001;
        push_beats(3'b001, 2'b00, 4);
        tick(3);
        bus_ready = 1'b0;
        tick(5);
        check("stall_grant_held", {5'd0, grant}, 8'h01);
        bus_ready = 1'b1;
        tick(2);
        check("stall_release", {5'd0, grant}, 8'h00);
        req = 3'b000;
        tick(1);

        // 5 owner 2 preempted with req=101: 0 goes next, then 2
        req = 3'b101;
        push_beats(3'b100, 2'b10, 4);
        push_beats(3'b001, 2'b00, 4);
        tick(1);
        check("pre_first_grant", {5'd0, grant}, 8'h04);
        tick(5);
        check("pre_next_grant", {5'd0, grant}, 8'h01);
        tick(5);
        check("pre_back_to_2", {5'd0, grant}, 8'h04);
        req = 3'b000;
        tick(2);

        // 6 async reset mid-burst
        req = 3'b100;
        push_beats(3'b100, 2'b10, 2);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("arst_grant", {5'd0, grant}, 8'h00);
        check("arst_sel", {6'd0, sel}, 8'h03);
        check("arst_busy", {7'd0, busy}, 8'h00);
        check("arst_valid", {7'd0, bus_valid}, 8'h00);
        #2;
        rst_n = 1'b1;
        push_beats(3'b100, 2'b10, 4);
        tick(1);
        check("arst_regrant", {5'd0, grant}, 8'h04);
        check("arst_regrant_sel", {6'd0, sel}, 8'h02);
        tick(4);
        req = 3'b000;
        tick(2);
        check("final_idle", {5'd0, grant}, 8'h00);
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
